vp_cfg_ctrl: RTL and testbench
==============================

// Module: vp_cfg_ctrl
// PURPOSE
// - Frame-synchronous configuration controller for the video-process chain (cutter/filter/scaler/color/edge/binarizer/filler).
// - Captures the bus-side VP_CR/VP_START/VP_END/VP_SCALER words on an update toggle and range-checks them.
// - Commits valid settings only at a frame boundary (vi_vs rise), so stages never see a mid-frame change.
// - Sits in the vi_clk domain between the AHB register file and the VP datapath.
// PARAMETERS
// - H_DISP  1280  input frame width; legal END_X upper bound
// - V_DISP  720   input frame height; legal END_Y upper bound
// - XW      11    X coordinate/resolution width
// - YW      11    Y coordinate/resolution width
// PORTS
// - clk           in   1   vi_clk
// - rst_n         in   1   reset, synchronous, active-low
// - upd_tgl       in   1   bus-domain toggle; each edge = new word set (words held stable >=4 clk after edge)
// - vp_cr         in   32  [0]cut_en [2:1]filt_mode [3]scl_en [4]col_en [5]edge_en [6]bin_en [7]fill_en [9:8]fill_mode [31]imm
// - vp_start      in   32  [XW-1:0]START_X, [16+YW-1:16]START_Y
// - vp_end        in   32  [XW-1:0]END_X, [16+YW-1:16]END_Y
// - vp_scaler     in   32  [XW-1:0]OUT_X_RES, [16+YW-1:16]OUT_Y_RES (output res minus 1)
// - vi_vs         in   1   input vsync, active-high
// - cfg_*         out  -   active enables/modes, one port per vp_cr field (imm excluded)
// - start_x/y, end_x/y, out_x_res/out_y_res  out  XW/YW  active geometry
// - in_x_res/in_y_res  out  XW/YW  registered END-START-1
// - cfg_pending   out  1   valid set waiting for frame boundary
// - cfg_applied   out  1   1-cycle pulse on commit
// - cfg_err       out  1   sticky; set on rejected set, cleared by next accepted set
// - frame_cnt     out  16  vs-rise count, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: cut_en=1, filt_mode=01, scl_en=1, fill_en=1, other enables 0, fill_mode=00; start=0, end=H_DISP/V_DISP,
//   out_res=H_DISP-1/V_DISP-1, in_res=H_DISP-1/V_DISP-1; pending/applied/err=0; frame_cnt=0; FSM->IDLE; sync flops 0.
// - upd_tgl: 2-flop synchronizer + edge detect flop; upd = s2^s3; detect latency 3 clk after edge.
// - vs_rise = vi_vs & ~vs_d (vs_d registered).
// - FSM IDLE: upd -> CAPTURE.
// - CAPTURE (1 clk): latch all four words into capture regs -> CHECK.
// - CHECK (1 clk), legal iff START_X<END_X<=H_DISP, START_Y<END_Y<=V_DISP, OUT_X_RES<H_DISP, OUT_Y_RES<V_DISP:
//   - illegal -> set cfg_err, drop set -> IDLE.
//   - legal & imm -> COMMIT.
//   - legal & ~imm -> copy to shadow, set pending -> PENDING.
// - PENDING: vs_rise -> COMMIT; upd -> CAPTURE (latest set wins; old shadow discarded only if new set legal).
// - COMMIT (1 clk): shadow->active, in_res recomputed, pending=0, err=0, applied=1 (visible next cycle) -> IDLE.
//   - Active outputs change exactly 1 clk after the vs_rise cycle.
// - upd during CAPTURE/CHECK/COMMIT: held in 1-bit flag, serviced on return to IDLE/PENDING; no edge lost;
//   multiple edges merge into one update.
// - vs_rise and upd in the same PENDING cycle: commit wins; flag serviced next cycle.
// - frame_cnt increments on every vs_rise regardless of FSM state.
// - Arithmetic: in_res = end-start-1 in XW/YW bits; legality guarantees no underflow.
// - Mid-operation reset: capture/shadow/pending dropped; outputs return to reset values next edge.
// STRUCTURE
// - vp_cfg_defs.vh: vp_cr bit offsets, field widths, FSM state encodings, reset default constants.
// - Sub-module vp_cfg_check: combinational legality check of the captured geometry (params H_DISP/V_DISP/XW/YW).
// - Top holds synchronizer, FSM, capture/shadow/active registers, frame counter.
// TESTING
// - Reset -> defaults read back (end_x=1280, out_y_res=719, filt_mode=01, in_x_res=1279), pending=0.
// - Toggle with START=(128,72), END=(768,432), imm=0, mid-frame -> pending=1 after 5 clk; no output change until vs_rise;
//   1 clk later start_x=128, in_x_res=639, applied pulse.
// - Illegal END_X=1300 -> cfg_err=1, pending=0, active unchanged; next legal set commits and clears err.
// - imm=1, OUT_X_RES=639/OUT_Y_RES=359 -> commit 5 clk after toggle without vs.
// - Two toggles 2 clk apart, then vs_rise -> only second set active; one applied pulse.
// - vs_rise same cycle as toggle detect in PENDING -> first set commits, second pending; rst_n low mid-PENDING -> defaults.

Source files
------------

// File: rtl/vp_cfg_ctrl_pkg.sv
// Shared definitions for the VP configuration controller: VP_CR field offsets,
// FSM state encoding, the mode-bit bundle and its reset value.
package vp_cfg_ctrl_pkg;

    localparam int CR_CUT_EN    = 0;
    localparam int CR_FILT_MODE = 1;
    localparam int CR_SCL_EN    = 3;
    localparam int CR_COL_EN    = 4;
    localparam int CR_EDGE_EN   = 5;
    localparam int CR_BIN_EN    = 6;
    localparam int CR_FILL_EN   = 7;
    localparam int CR_FILL_MODE = 8;
    localparam int CR_IMM       = 31;
    localparam int Y_OFS        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CHECK,
        ST_PENDING,
        ST_COMMIT
    } vp_state_e;

    typedef struct packed {
        logic       cut_en;
        logic [1:0] filt_mode;
        logic       scl_en;
        logic       col_en;
        logic       edge_en;
        logic       bin_en;
        logic       fill_en;
        logic [1:0] fill_mode;
    } vp_mode_t;

    localparam vp_mode_t MODE_RST = '{
        cut_en: 1'b1, filt_mode: 2'b01, scl_en: 1'b1, col_en: 1'b0,
        edge_en: 1'b0, bin_en: 1'b0, fill_en: 1'b1, fill_mode: 2'b00
    };

    function automatic vp_mode_t decode_cr(input logic [9:0] cr);
        vp_mode_t m;
        m.cut_en    = cr[CR_CUT_EN];
        m.filt_mode = cr[CR_FILT_MODE +: 2];
        m.scl_en    = cr[CR_SCL_EN];
        m.col_en    = cr[CR_COL_EN];
        m.edge_en   = cr[CR_EDGE_EN];
        m.bin_en    = cr[CR_BIN_EN];
        m.fill_en   = cr[CR_FILL_EN];
        m.fill_mode = cr[CR_FILL_MODE +: 2];
        return m;
    endfunction

endpackage

// File: rtl/vp_cfg_ctrl_if.sv
// Bus-side configuration word set: the update toggle plus the four register
// words it qualifies.
interface vp_cfg_ctrl_if;
    logic        upd_tgl;
    logic [31:0] vp_cr;
    logic [31:0] vp_start;
    logic [31:0] vp_end;
    logic [31:0] vp_scaler;

    modport master (output upd_tgl, vp_cr, vp_start, vp_end, vp_scaler);
    modport slave  (input  upd_tgl, vp_cr, vp_start, vp_end, vp_scaler);
endinterface

// File: rtl/vp_cfg_ctrl_check.sv
// Combinational legality check of a captured geometry set against the input
// frame size.
module vp_cfg_ctrl_check #(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int XW     = 11,
    parameter int YW     = 11
) (
    input  logic [XW-1:0] start_x,
    input  logic [XW-1:0] end_x,
    input  logic [XW-1:0] out_x_res,
    input  logic [YW-1:0] start_y,
    input  logic [YW-1:0] end_y,
    input  logic [YW-1:0] out_y_res,
    output logic          legal
);
    localparam logic [XW-1:0] X_LIM = XW'(H_DISP);
    localparam logic [YW-1:0] Y_LIM = YW'(V_DISP);

    assign legal = (start_x < end_x) && (end_x <= X_LIM) &&
                   (start_y < end_y) && (end_y <= Y_LIM) &&
                   (out_x_res < X_LIM) && (out_y_res < Y_LIM);
endmodule

// File: rtl/vp_cfg_ctrl.sv
// Frame-synchronous configuration controller: captures bus word sets on an
// update toggle, range-checks them and commits them to the VP chain at vsync.
module vp_cfg_ctrl
    import vp_cfg_ctrl_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int XW     = 11,
    parameter int YW     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    vp_cfg_ctrl_if.slave     bus,
    input  logic             vi_vs,
    output logic             cfg_cut_en,
    output logic [1:0]       cfg_filt_mode,
    output logic             cfg_scl_en,
    output logic             cfg_col_en,
    output logic             cfg_edge_en,
    output logic             cfg_bin_en,
    output logic             cfg_fill_en,
    output logic [1:0]       cfg_fill_mode,
    output logic [XW-1:0]    start_x,
    output logic [YW-1:0]    start_y,
    output logic [XW-1:0]    end_x,
    output logic [YW-1:0]    end_y,
    output logic [XW-1:0]    out_x_res,
    output logic [YW-1:0]    out_y_res,
    output logic [XW-1:0]    in_x_res,
    output logic [YW-1:0]    in_y_res,
    output logic             cfg_pending,
    output logic             cfg_applied,
    output logic             cfg_err,
    output logic [15:0]      frame_cnt
);
    typedef struct packed {
        logic [XW-1:0] sx;
        logic [XW-1:0] ex;
        logic [XW-1:0] ox;
        logic [YW-1:0] sy;
        logic [YW-1:0] ey;
        logic [YW-1:0] oy;
    } geom_t;

    localparam geom_t GEOM_RST = '{
        sx: '0, ex: XW'(H_DISP), ox: XW'(H_DISP - 1),
        sy: '0, ey: YW'(V_DISP), oy: YW'(V_DISP - 1)
    };

    logic          s1_q, s2_q, s3_q, vs_d_q;
    vp_state_e     state_q, state_d;
    logic          upd_flag_q, upd_flag_d;
    vp_mode_t      cap_mode_q, cap_mode_d, shd_mode_q, shd_mode_d, act_mode_q, act_mode_d;
    geom_t         cap_geom_q, cap_geom_d, shd_geom_q, shd_geom_d, act_geom_q, act_geom_d;
    logic          cap_imm_q, cap_imm_d;
    logic [XW-1:0] in_x_q, in_x_d;
    logic [YW-1:0] in_y_q, in_y_d;
    logic          pending_q, pending_d, applied_q, applied_d, err_q, err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          upd, vs_rise, legal;
    logic          unused_bits;

    assign upd     = s2_q ^ s3_q;
    assign vs_rise = vi_vs & ~vs_d_q;

    vp_cfg_ctrl_check #(.H_DISP(H_DISP), .V_DISP(V_DISP), .XW(XW), .YW(YW)) u_check (
        .start_x  (cap_geom_q.sx),
        .end_x    (cap_geom_q.ex),
        .out_x_res(cap_geom_q.ox),
        .start_y  (cap_geom_q.sy),
        .end_y    (cap_geom_q.ey),
        .out_y_res(cap_geom_q.oy),
        .legal    (legal)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case infers a latch.
        state_d     = state_q;
        upd_flag_d  = upd_flag_q;
        cap_mode_d  = cap_mode_q;
        cap_geom_d  = cap_geom_q;
        cap_imm_d   = cap_imm_q;
        shd_mode_d  = shd_mode_q;
        shd_geom_d  = shd_geom_q;
        act_mode_d  = act_mode_q;
        act_geom_d  = act_geom_q;
        in_x_d      = in_x_q;
        in_y_d      = in_y_q;
        pending_d   = pending_q;
        err_d       = err_q;
        applied_d   = 1'b0;
        frame_cnt_d = frame_cnt_q + 16'(vs_rise);

        unique case (state_q)
            ST_IDLE: begin
                if (upd || upd_flag_q) begin
                    upd_flag_d = 1'b0;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cap_mode_d = decode_cr(bus.vp_cr[9:0]);
                cap_imm_d  = bus.vp_cr[CR_IMM];
                cap_geom_d = '{
                    sx: bus.vp_start[XW-1:0],  ex: bus.vp_end[XW-1:0],  ox: bus.vp_scaler[XW-1:0],
                    sy: bus.vp_start[Y_OFS +: YW], ey: bus.vp_end[Y_OFS +: YW], oy: bus.vp_scaler[Y_OFS +: YW]
                };
                upd_flag_d = upd_flag_q | upd;
                state_d    = ST_CHECK;
            end
            ST_CHECK: begin
                upd_flag_d = upd_flag_q | upd;
                if (!legal) begin
                    // A rejected set leaves any earlier valid shadow waiting for its frame.
                    err_d   = 1'b1;
                    state_d = pending_q ? ST_PENDING : ST_IDLE;
                end else begin
                    shd_mode_d = cap_mode_q;
                    shd_geom_d = cap_geom_q;
                    err_d      = 1'b0;
                    if (cap_imm_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        pending_d = 1'b1;
                        state_d   = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (vs_rise) begin
                    upd_flag_d = upd_flag_q | upd;
                    state_d    = ST_COMMIT;
                end else if (upd || upd_flag_q) begin
                    upd_flag_d = 1'b0;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_COMMIT: begin
                act_mode_d = shd_mode_q;
                act_geom_d = shd_geom_q;
                in_x_d     = shd_geom_q.ex - shd_geom_q.sx - XW'(1);
                in_y_d     = shd_geom_q.ey - shd_geom_q.sy - YW'(1);
                pending_d  = 1'b0;
                err_d      = 1'b0;
                applied_d  = 1'b1;
                upd_flag_d = upd_flag_q | upd;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            vs_d_q      <= 1'b0;
            state_q     <= ST_IDLE;
            upd_flag_q  <= 1'b0;
            cap_mode_q  <= MODE_RST;
            cap_geom_q  <= GEOM_RST;
            cap_imm_q   <= 1'b0;
            shd_mode_q  <= MODE_RST;
            shd_geom_q  <= GEOM_RST;
            act_mode_q  <= MODE_RST;
            act_geom_q  <= GEOM_RST;
            in_x_q      <= XW'(H_DISP - 1);
            in_y_q      <= YW'(V_DISP - 1);
            pending_q   <= 1'b0;
            applied_q   <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            s1_q        <= bus.upd_tgl;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            vs_d_q      <= vi_vs;
            state_q     <= state_d;
            upd_flag_q  <= upd_flag_d;
            cap_mode_q  <= cap_mode_d;
            cap_geom_q  <= cap_geom_d;
            cap_imm_q   <= cap_imm_d;
            shd_mode_q  <= shd_mode_d;
            shd_geom_q  <= shd_geom_d;
            act_mode_q  <= act_mode_d;
            act_geom_q  <= act_geom_d;
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            pending_q   <= pending_d;
            applied_q   <= applied_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cfg_cut_en    = act_mode_q.cut_en;
    assign cfg_filt_mode = act_mode_q.filt_mode;
    assign cfg_scl_en    = act_mode_q.scl_en;
    assign cfg_col_en    = act_mode_q.col_en;
    assign cfg_edge_en   = act_mode_q.edge_en;
    assign cfg_bin_en    = act_mode_q.bin_en;
    assign cfg_fill_en   = act_mode_q.fill_en;
    assign cfg_fill_mode = act_mode_q.fill_mode;
    assign start_x       = act_geom_q.sx;
    assign start_y       = act_geom_q.sy;
    assign end_x         = act_geom_q.ex;
    assign end_y         = act_geom_q.ey;
    assign out_x_res     = act_geom_q.ox;
    assign out_y_res     = act_geom_q.oy;
    assign in_x_res      = in_x_q;
    assign in_y_res      = in_y_q;
    assign cfg_pending   = pending_q;
    assign cfg_applied   = applied_q;
    assign cfg_err       = err_q;
    assign frame_cnt     = frame_cnt_q;

    assign unused_bits = ^{bus.vp_cr[30:10],
                           bus.vp_start[Y_OFS-1:XW],  bus.vp_start[31:Y_OFS+YW],
                           bus.vp_end[Y_OFS-1:XW],    bus.vp_end[31:Y_OFS+YW],
                           bus.vp_scaler[Y_OFS-1:XW], bus.vp_scaler[31:Y_OFS+YW]};
endmodule

// File: tb/tb_vp_cfg_ctrl.sv
// Directed self-checking bench for vp_cfg_ctrl: reset defaults, deferred and
// immediate commits, rejection, merged updates, vs/update collision, reset.
module tb_vp_cfg_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vi_vs = 1'b0;
    logic        cfg_cut_en, cfg_scl_en, cfg_col_en, cfg_edge_en, cfg_bin_en, cfg_fill_en;
    logic [1:0]  cfg_filt_mode, cfg_fill_mode;
    logic [10:0] start_x, start_y, end_x, end_y, out_x_res, out_y_res, in_x_res, in_y_res;
    logic        cfg_pending, cfg_applied, cfg_err;
    logic [15:0] frame_cnt;
    int          checks = 0;
    int          failures = 0;

    vp_cfg_ctrl_if bus ();

    vp_cfg_ctrl #(.H_DISP(1280), .V_DISP(720), .XW(11), .YW(11)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .vi_vs(vi_vs),
        .cfg_cut_en(cfg_cut_en), .cfg_filt_mode(cfg_filt_mode), .cfg_scl_en(cfg_scl_en),
        .cfg_col_en(cfg_col_en), .cfg_edge_en(cfg_edge_en), .cfg_bin_en(cfg_bin_en),
        .cfg_fill_en(cfg_fill_en), .cfg_fill_mode(cfg_fill_mode),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
        .out_x_res(out_x_res), .out_y_res(out_y_res), .in_x_res(in_x_res), .in_y_res(in_y_res),
        .cfg_pending(cfg_pending), .cfg_applied(cfg_applied), .cfg_err(cfg_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] cr, input int sx, input int sy, input int ex,
                        input int ey, input int ox, input int oy);
        bus.vp_cr     = cr;
        bus.vp_start  = (32'(sy) << 16) | 32'(sx);
        bus.vp_end    = (32'(ey) << 16) | 32'(ex);
        bus.vp_scaler = (32'(oy) << 16) | 32'(ox);
        bus.upd_tgl   = ~bus.upd_tgl;
    endtask

    int n_applied;

    initial begin
        bus.upd_tgl = 1'b0;
        bus.vp_cr = '0; bus.vp_start = '0; bus.vp_end = '0; bus.vp_scaler = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset defaults
        check("rst_end_x", end_x, 1280);
        check("rst_end_y", end_y, 720);
        check("rst_out_y_res", out_y_res, 719);
        check("rst_out_x_res", out_x_res, 1279);
        check("rst_filt_mode", cfg_filt_mode, 1);
        check("rst_en_bits", {cfg_cut_en, cfg_scl_en, cfg_col_en, cfg_edge_en, cfg_bin_en, cfg_fill_en}, 6'b110001);
        check("rst_in_x_res", in_x_res, 1279);
        check("rst_in_y_res", in_y_res, 719);
        check("rst_start_x", start_x, 0);
        check("rst_flags", {cfg_pending, cfg_applied, cfg_err}, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Deferred set: cut_en, filt_mode=2, col_en
        send(32'h0000_0015, 128, 72, 768, 432, 1279, 719);
        tick(4);
        check("a_pending_early", cfg_pending, 0);
        tick(1);
        check("a_pending", cfg_pending, 1);
        check("a_hold_start_x", start_x, 0);
        tick(3);
        check("a_hold_start_x2", start_x, 0);
        vi_vs = 1'b1;
        tick(1);
        check("a_vs_cycle_start_x", start_x, 0);
        check("a_vs_cycle_applied", cfg_applied, 0);
        check("a_frame_cnt", frame_cnt, 1);
        tick(1);
        check("a_start_x", start_x, 128);
        check("a_start_y", start_y, 72);
        check("a_end_x", end_x, 768);
        check("a_in_x_res", in_x_res, 639);
        check("a_in_y_res", in_y_res, 359);
        check("a_filt_mode", cfg_filt_mode, 2);
        check("a_col_en", cfg_col_en, 1);
        check("a_applied", cfg_applied, 1);
        check("a_pending_clr", cfg_pending, 0);
        tick(1);
        check("a_applied_pulse", cfg_applied, 0);
        vi_vs = 1'b0;
        tick(2);

        // Illegal END_X, then a legal deferred set
        send(32'h0000_0015, 0, 0, 1300, 720, 1279, 719);
        tick(5);
        check("ill_err", cfg_err, 1);
        check("ill_pending", cfg_pending, 0);
        tick(4);
        check("ill_start_x", start_x, 128);
        check("ill_end_x", end_x, 768);
        send(32'h0000_0015, 10, 20, 650, 500, 1279, 719);
        tick(5);
        check("leg_pending", cfg_pending, 1);
        check("leg_err_clr", cfg_err, 0);
        vi_vs = 1'b1;
        tick(2);
        check("leg_start_x", start_x, 10);
        check("leg_in_x_res", in_x_res, 639);
        check("leg_in_y_res", in_y_res, 479);
        check("leg_frame_cnt", frame_cnt, 2);
        vi_vs = 1'b0;
        tick(3);

        // Immediate set: no vsync needed
        send(32'h8000_0289, 0, 0, 1280, 720, 639, 359);
        tick(5);
        check("imm_applied_early", cfg_applied, 0);
        check("imm_out_x_old", out_x_res, 1279);
        tick(1);
        check("imm_applied", cfg_applied, 1);
        check("imm_out_x_res", out_x_res, 639);
        check("imm_out_y_res", out_y_res, 359);
        check("imm_fill_mode", cfg_fill_mode, 2);
        check("imm_filt_mode", cfg_filt_mode, 0);
        check("imm_in_x_res", in_x_res, 1279);
        check("imm_frame_cnt", frame_cnt, 2);
        tick(3);

        // Two toggles 2 clk apart merge into one deferred update
        send(32'h0000_0001, 100, 100, 500, 400, 1279, 719);
        tick(2);
        send(32'h0000_0001, 200, 50, 600, 350, 1279, 719);
        tick(10);
        check("mrg_pending", cfg_pending, 1);
        check("mrg_hold_start_x", start_x, 0);
        vi_vs = 1'b1;
        n_applied = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_applied += int'(cfg_applied);
        end
        check("mrg_applied_count", n_applied, 1);
        check("mrg_start_x", start_x, 200);
        check("mrg_end_x", end_x, 600);
        check("mrg_in_x_res", in_x_res, 399);
        check("mrg_in_y_res", in_y_res, 299);
        vi_vs = 1'b0;
        tick(2);

        // vsync rise in the same PENDING cycle as a new update
        send(32'h0000_0001, 16, 8, 656, 488, 1279, 719);
        tick(5);
        check("col_pending_d", cfg_pending, 1);
        send(32'h0000_0001, 32, 16, 672, 496, 1279, 719);
        tick(2);
        vi_vs = 1'b1;
        tick(1);
        check("col_vs_cycle_start_x", start_x, 200);
        tick(1);
        check("col_start_x", start_x, 16);
        check("col_applied", cfg_applied, 1);
        check("col_frame_cnt", frame_cnt, 4);
        tick(3);
        check("col_pending_e", cfg_pending, 1);
        check("col_hold_start_x", start_x, 16);

        // Reset while a set is pending
        rst_n = 1'b0;
        tick(1);
        check("mr_pending", cfg_pending, 0);
        check("mr_start_x", start_x, 0);
        check("mr_end_x", end_x, 1280);
        check("mr_in_x_res", in_x_res, 1279);
        check("mr_filt_mode", cfg_filt_mode, 1);
        check("mr_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        vi_vs = 1'b0;
        tick(3);
        vi_vs = 1'b1;
        n_applied = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_applied += int'(cfg_applied);
        end
        check("mr_no_commit", n_applied, 0);
        check("mr_start_x_after_vs", start_x, 0);
        check("mr_frame_cnt_after_vs", frame_cnt, 1);
        vi_vs = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
